// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction/select/tag in, immediate/tag/flags out.
// Latency: none (wires only).
// Backpressure: valid_i/ready_o upstream, valid_o/ready_i downstream.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic [24:0]      instr_31_7_i;
  logic [2:0]       imm_src_i;
  logic [TAG_W-1:0] tag_i;
  logic             valid_i;
  logic             ready_o;
  logic [XLEN-1:0]  imm_ext_o;
  logic [TAG_W-1:0] tag_o;
  logic             illegal_o;
  logic             valid_o;
  logic             ready_i;
  logic [7:0]       err_cnt_o;

  // Block side: consumes instructions, produces immediates.
  modport slave (
    input  instr_31_7_i, imm_src_i, tag_i, valid_i, ready_i,
    output ready_o, imm_ext_o, tag_o, illegal_o, valid_o, err_cnt_o
  );

  // Environment side: drives instructions, sinks immediates.
  modport master (
    output instr_31_7_i, imm_src_i, tag_i, valid_i, ready_i,
    input  ready_o, imm_ext_o, tag_o, illegal_o, valid_o, err_cnt_o
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with registered valid/ready output stage and illegal-select counter.
// Latency: 1 cycle from input transfer to valid_o.
// Backpressure: default ready_o = !valid_o || ready_i; with IMM_GEN_PIPE_SKID_EN a one-entry skid
//   buffer makes ready_o a register (= !skid_full) so ready_o never depends on ready_i.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic           clk_i,
  input logic           rst_n_i,
  imm_gen_pipe_if.slave bus
);

  logic [31:7]      instr;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_ill;
  logic             rdy;
  logic             in_xfer;
  logic             out_free;

  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_ill;
  logic             out_vld;
  logic [7:0]       err_cnt;

  assign instr    = bus.instr_31_7_i;
  assign in_xfer  = bus.valid_i && rdy;
  // Output slot can take a new entry when empty or being drained this edge.
  assign out_free = !out_vld || bus.ready_i;

  assign bus.ready_o   = rdy;
  assign bus.imm_ext_o = out_imm;
  assign bus.tag_o     = out_tag;
  assign bus.illegal_o = out_ill;
  assign bus.valid_o   = out_vld;
  assign bus.err_cnt_o = err_cnt;

  // Decode the format select into a sign- or zero-extended immediate.
  always_comb begin
    dec_imm = '0;
    dec_ill = 1'b0;
    case (bus.imm_src_i)
      3'b000: dec_imm = XLEN'($signed(instr[31:20]));
      3'b001: dec_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      3'b010: dec_imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      3'b011: dec_imm = XLEN'($signed({instr[31:12], 12'b0}));
      3'b100: dec_imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      3'b101: begin
        // RV64 shift amounts carry one extra bit.
        if (XLEN == 64) dec_imm[5:0] = instr[25:20];
        else            dec_imm[4:0] = instr[24:20];
      end
      3'b110: dec_imm[4:0] = instr[19:15];
      default: dec_ill = 1'b1;
    endcase
  end

`ifdef IMM_GEN_PIPE_SKID_EN
  logic [XLEN-1:0]  sk_imm;
  logic [TAG_W-1:0] sk_tag;
  logic             sk_ill;
  logic             sk_full;
  logic             rdy_q;

  assign rdy = rdy_q;

  // Output register refills from the skid entry first, so ordering is kept; a stalled accept parks in the skid.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      out_imm <= '0;
      out_tag <= '0;
      out_ill <= 1'b0;
      out_vld <= 1'b0;
      sk_imm  <= '0;
      sk_tag  <= '0;
      sk_ill  <= 1'b0;
      sk_full <= 1'b0;
      rdy_q   <= 1'b1;
    end else if (out_free) begin
      if (sk_full) begin
        out_imm <= sk_imm;
        out_tag <= sk_tag;
        out_ill <= sk_ill;
        out_vld <= 1'b1;
        sk_full <= 1'b0;
        rdy_q   <= 1'b1;
      end else if (in_xfer) begin
        out_imm <= dec_imm;
        out_tag <= bus.tag_i;
        out_ill <= dec_ill;
        out_vld <= 1'b1;
      end else begin
        out_vld <= 1'b0;
      end
    end else if (in_xfer) begin
      sk_imm  <= dec_imm;
      sk_tag  <= bus.tag_i;
      sk_ill  <= dec_ill;
      sk_full <= 1'b1;
      rdy_q   <= 1'b0;
    end
  end
`else
  assign rdy = out_free;

  // Load on accept (which implies the slot is free); otherwise drop valid once drained.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      out_imm <= '0;
      out_tag <= '0;
      out_ill <= 1'b0;
      out_vld <= 1'b0;
    end else if (in_xfer) begin
      out_imm <= dec_imm;
      out_tag <= bus.tag_i;
      out_ill <= dec_ill;
      out_vld <= 1'b1;
    end else if (bus.ready_i) begin
      out_vld <= 1'b0;
    end
  end
`endif

  // Count accepted illegal selects, sticking at 255.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      err_cnt <= 8'd0;
    end else if (in_xfer && dec_ill && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
// Expected immediates come from an arithmetic reference model; a negedge monitor pushes/pops.
// Works with or without IMM_GEN_PIPE_SKID_EN.
module tb_imm_gen_pipe;

  logic clk;
  logic rst_n;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (.clk_i(clk), .rst_n_i(rst_n), .bus(b32.slave));
  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (.clk_i(clk), .rst_n_i(rst_n), .bus(b64.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   acc32 = 0;
  int   ill_model = 0;

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
    end
  endfunction

  // Reference model: immediate rules applied with signed arithmetic on a full 32-bit instruction.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src, input int xlen);
    longint sx;
    longint r;
    sx = longint'($signed(ins));
    case (src)
      3'd0: r = sx >>> 20;
      3'd1: r = ((sx >>> 25) <<< 5) | longint'(ins[11:7]);
      3'd2: r = ((sx >>> 31) <<< 12) | (longint'(ins[7]) << 11) | (longint'(ins[30:25]) << 5)
                | (longint'(ins[11:8]) << 1);
      3'd3: r = (sx >>> 12) <<< 12;
      3'd4: r = ((sx >>> 31) <<< 20) | (longint'(ins[19:12]) << 12) | (longint'(ins[20]) << 11)
                | (longint'(ins[30:21]) << 1);
      3'd5: r = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      3'd6: r = longint'(ins[19:15]);
      default: r = 0;
    endcase
    if (xlen == 32) r = r & 64'h0000_0000_FFFF_FFFF;
    return r;
  endfunction

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Monitor: pop/compare on output transfers, push model results on input transfers.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] ins;
    if (!rst_n) begin
      q32.delete();
      q64.delete();
      ill_model = 0;
    end else begin
      if (b32.valid_o && b32.ready_i) begin
        if (q32.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL out32_unexpected: got imm 0x%0h, required no output", b32.imm_ext_o);
        end else begin
          e = q32.pop_front();
          chk("out32_imm", {32'b0, b32.imm_ext_o}, e.imm);
          chk("out32_tag", 64'(b32.tag_o), 64'(e.tag));
          chk("out32_ill", 64'(b32.illegal_o), 64'(e.ill));
        end
      end
      if (b64.valid_o && b64.ready_i) begin
        if (q64.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL out64_unexpected: got imm 0x%0h, required no output", b64.imm_ext_o);
        end else begin
          e = q64.pop_front();
          chk("out64_imm", b64.imm_ext_o, e.imm);
          chk("out64_tag", 64'(b64.tag_o), 64'(e.tag));
          chk("out64_ill", 64'(b64.illegal_o), 64'(e.ill));
        end
      end
`ifndef IMM_GEN_PIPE_SKID_EN
      chk("ready_comb", 64'(b32.ready_o), 64'(!b32.valid_o || b32.ready_i));
`endif
      if (b32.valid_i && b32.ready_o) begin
        ins   = {b32.instr_31_7_i, 7'b0};
        e.imm = ref_imm(ins, b32.imm_src_i, 32);
        e.tag = b32.tag_i;
        e.ill = (b32.imm_src_i == 3'b111);
        q32.push_back(e);
        acc32++;
        if (e.ill) ill_model++;
      end
      if (b64.valid_i && b64.ready_o) begin
        ins   = {b64.instr_31_7_i, 7'b0};
        e.imm = ref_imm(ins, b64.imm_src_i, 64);
        e.tag = b64.tag_i;
        e.ill = (b64.imm_src_i == 3'b111);
        q64.push_back(e);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src,
                       input logic [4:0] tg, input logic rdy);
    b32.valid_i = v; b32.instr_31_7_i = ins[31:7]; b32.imm_src_i = src; b32.tag_i = tg; b32.ready_i = rdy;
    b64.valid_i = v; b64.instr_31_7_i = ins[31:7]; b64.imm_src_i = src; b64.tag_i = tg; b64.ready_i = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [63:0] e32, input logic [63:0] e64);
    chk({nm, "_vld"}, 64'(b32.valid_o && b64.valid_o), 64'd1);
    chk({nm, "_imm32"}, {32'b0, b32.imm_ext_o}, e32);
    chk({nm, "_imm64"}, b64.imm_ext_o, e64);
  endtask

  task automatic drain(input string nm);
    int c = 0;
    drive(1'b0, 32'd0, 3'd0, 5'd0, 1'b1);
    while ((q32.size() != 0 || q64.size() != 0 || b32.valid_o || b64.valid_o) && c < 50) begin
      step();
      c++;
    end
    chk({nm, "_drained"}, 64'(q32.size() + q64.size()), 64'd0);
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)), 5'($urandom),
            1'($urandom_range(0, 3) != 0));
      step();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int a0;
    int ill0;
    int extra;
    logic [31:0] snap_imm;
    logic [4:0]  snap_tag;

    rst_n = 1'b0;
    drive(1'b0, 32'd0, 3'd0, 5'd0, 1'b1);
    repeat (2) step();
    chk("rst_vld", 64'(b32.valid_o || b64.valid_o), 64'd0);
    chk("rst_imm", {32'b0, b32.imm_ext_o} | b64.imm_ext_o, 64'd0);
    chk("rst_tag", 64'(b32.tag_o | b64.tag_o), 64'd0);
    chk("rst_ill", 64'(b32.illegal_o || b64.illegal_o), 64'd0);
    chk("rst_err", 64'(b32.err_cnt_o | b64.err_cnt_o), 64'd0);
    rst_n = 1'b1;
    step();
    chk("idle_ready", 64'(b32.ready_o && b64.ready_o), 64'd1);

    // Directed formats, back-to-back, checked one cycle after the accepting edge.
    drive(1'b1, 32'hFFF00093, 3'b000, 5'd1, 1'b1); step();
    expect_out("i_neg1", 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1'b1, 32'hFE000EE3, 3'b010, 5'd2, 1'b1); step();
    expect_out("b_neg4", 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(1'b1, 32'h123450B7, 3'b011, 5'd3, 1'b1); step();
    expect_out("u_lui", 64'h1234_5000, 64'h0000_0000_1234_5000);
    drive(1'b1, 32'h03F09093, 3'b101, 5'd4, 1'b1); step();
    expect_out("shamt", 64'h1F, 64'h3F);
    drive(1'b1, 32'h000D8073, 3'b110, 5'd5, 1'b1); step();
    expect_out("zimm", 64'h1B, 64'h1B);
    drive(1'b1, 32'hFFFFFFFF, 3'b111, 5'd6, 1'b1); step();
    expect_out("illegal", 64'h0, 64'h0);
    chk("illegal_flag", 64'(b32.illegal_o && b64.illegal_o), 64'd1);
    drain("directed");
    chk("err_one", 64'(b32.err_cnt_o), 64'd1);

    // Stall: fill the output, then keep offering while ready_i=0 for three cycles.
    drive(1'b1, $urandom, 3'($urandom_range(0, 6)), 5'($urandom), 1'b0); step();
    chk("stall_vld", 64'(b32.valid_o), 64'd1);
    snap_imm = b32.imm_ext_o;
    snap_tag = b32.tag_o;
    a0 = acc32;
    drive(1'b1, $urandom, 3'($urandom_range(0, 6)), 5'($urandom), 1'b0);
    repeat (3) begin
      step();
      chk("stall_hold_vld", 64'(b32.valid_o), 64'd1);
      chk("stall_hold_imm", 64'(b32.imm_ext_o), 64'(snap_imm));
      chk("stall_hold_tag", 64'(b32.tag_o), 64'(snap_tag));
    end
`ifdef IMM_GEN_PIPE_SKID_EN
    extra = 1;
`else
    extra = 0;
`endif
    chk("stall_extra_accepts", 64'(acc32 - a0), 64'(extra));
    chk("stall_ready", 64'(b32.ready_o || b64.ready_o), 64'd0);
    drain("stall");

    random_phase(400);
    drain("random");
    chk("err_random32", 64'(b32.err_cnt_o), 64'(sat255(ill_model)));
    chk("err_random64", 64'(b64.err_cnt_o), 64'(sat255(ill_model)));

    // 300 accepted illegal selects drive the counter into saturation.
    ill0 = ill_model;
    for (int c = 0; c < 3000; c++) begin
      if (ill_model - ill0 >= 300) break;
      drive(1'b1, $urandom, 3'b111, 5'($urandom), 1'($urandom_range(0, 3) != 0));
      step();
    end
    chk("ill_accepted", 64'(ill_model - ill0), 64'd300);
    drain("illegal");
    chk("err_sat32", 64'(b32.err_cnt_o), 64'd255);
    chk("err_sat64", 64'(b64.err_cnt_o), 64'd255);

    // Reset in the middle of a stall drops the held (and any skid) entry.
    drive(1'b1, $urandom, 3'($urandom_range(0, 6)), 5'($urandom), 1'b0); step();
    drive(1'b1, $urandom, 3'($urandom_range(0, 6)), 5'($urandom), 1'b0); step();
    chk("prerst_vld", 64'(b32.valid_o), 64'd1);
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 3'd0, 5'd0, 1'b0);
    step();
    chk("midrst_vld", 64'(b32.valid_o || b64.valid_o), 64'd0);
    chk("midrst_err32", 64'(b32.err_cnt_o), 64'd0);
    chk("midrst_err64", 64'(b64.err_cnt_o), 64'd0);
    rst_n = 1'b1;
    drive(1'b0, 32'd0, 3'd0, 5'd0, 1'b1);
    repeat (3) begin
      step();
      chk("postrst_idle", 64'(b32.valid_o || b64.valid_o), 64'd0);
    end

    random_phase(150);
    drain("final");
    chk("err_final", 64'(b32.err_cnt_o), 64'(sat255(ill_model)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning immediate output width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter TAG_W, default 5, meaning the width of the sideband tag carried alongside each immediate.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port instr_31_7_i, input, 25 bits: instruction bits [31:7].
REQ-006 The block SHALL have port imm_src_i, input, 3 bits: immediate format select.
REQ-007 The block SHALL have port tag_i, input, TAG_W bits: sideband carried unchanged to tag_o.
REQ-008 The block SHALL have ports valid_i (input, 1 bit) and ready_o (output, 1 bit) forming the upstream handshake.
REQ-009 The block SHALL have ports imm_ext_o (output, XLEN bits) and tag_o (output, TAG_W bits): the result and its tag.
REQ-010 The block SHALL have port illegal_o, output, 1 bit, marking a result whose imm_src was 3'b111.
REQ-011 The block SHALL have ports valid_o (output, 1 bit) and ready_i (input, 1 bit) forming the downstream handshake.
REQ-012 The block SHALL have port err_cnt_o, output, 8 bits: saturating count of accepted illegal selects.

Function
REQ-013 A transfer SHALL occur on a rising edge where the valid and ready signals of that interface are both high.
REQ-014 Format decode SHALL be as follows, with bit indices taken relative to instr[31:7] and every sign-extension taken from instr[31] up to XLEN:
- 000 I: instr[31:20].
- 001 S: {instr[31:25], instr[11:7]}.
- 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- 011 U: {instr[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64.
- 100 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-015 Code 101 (shift amount) SHALL produce instr[24:20] zero-extended when XLEN=32, and instr[25:20] zero-extended when XLEN=64.
REQ-016 Code 110 (CSR zimm) SHALL produce instr[19:15] zero-extended.
REQ-017 Code 111 SHALL produce imm_ext_o=0 and illegal_o=1; every other code SHALL produce illegal_o=0.
REQ-018 Latency SHALL be exactly one cycle: a result accepted at edge N is presented with valid_o=1 after edge N.
REQ-019 Output signals SHALL be registered and SHALL hold stable while valid_o=1 and ready_i=0.
REQ-020 An accept while the downstream is stalled SHALL never overwrite the held result.
REQ-021 When the macro in REQ-027 is undefined, ready_o SHALL equal (!valid_o || ready_i), combinationally.
REQ-022 When an input and an output transfer occur on the same edge, the output register SHALL load the new result and valid_o SHALL stay 1.
REQ-023 err_cnt_o SHALL increment by 1 on each input transfer with imm_src_i=111.
REQ-024 err_cnt_o SHALL saturate at 255, and it SHALL NOT wrap.

Reset
REQ-025 While rst_n_i=0 at a clock edge, the block SHALL set valid_o=0, imm_ext_o=0, tag_o=0, illegal_o=0 and err_cnt_o=0, and SHALL discard any held or skid entry.
REQ-026 Reset asserted mid-stall SHALL drop the pending result, and no transfer SHALL be reported on that edge.

Configuration
REQ-027 The macro IMM_GEN_PIPE_SKID_EN SHALL select the buffering scheme.
- Defined: the block SHALL add a one-entry skid buffer, and ready_o SHALL be a register equal to !skid_full.
- Defined: an input accepted while the output is stalled SHALL go into the skid entry.
- Defined: the skid entry SHALL move to the output on the next output transfer.
- Defined: ready_o SHALL NOT depend combinationally on ready_i, and back-to-back throughput SHALL be one transfer per cycle.
- Undefined: behaviour SHALL be per REQ-021, with no skid storage.
- In both modes, ordering SHALL be preserved and no result SHALL be lost or duplicated.

Verification
REQ-028 The bench SHALL drive instr=0xFFF00093 with src=000 and ready_i=1, and SHALL check imm_ext_o=0xFFFFFFFF with valid_o=1 exactly one cycle later.
REQ-029 The bench SHALL drive instr=0xFE000EE3 with src=010 and then instr=0x123450B7 with src=011 back-to-back, and SHALL check outputs 0xFFFFFFFC and then 0x12345000 in order.
REQ-030 With XLEN=64, the bench SHALL drive instr=0x03F09093 with src=101, and SHALL check imm_ext_o=0x000000000000003F.
REQ-031 The bench SHALL hold ready_i=0 for 3 cycles with valid_i=1, and SHALL check the following:
- The output stays stable throughout the stall.
- With the macro undefined, ready_o=0.
- With the macro defined, one extra entry is accepted and ready_o then falls.
- On release, results emerge in order with no loss.
REQ-032 The bench SHALL issue 300 transfers with src=111, and SHALL check illegal_o=1, imm_ext_o=0 and err_cnt_o=255 at saturation.
REQ-033 The bench SHALL assert rst_n_i=0 during a stall, and SHALL check valid_o=0 and err_cnt_o=0 on the next cycle, with no stale result appearing afterwards.
